// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and default operand width.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: the borrow-domain counterpart of a full adder.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic borrow_in,
  output logic diff,
  output logic borrow_out
);

  assign diff       = a ^ b ^ borrow_in;
  assign borrow_out = (~a & b) | (~a & borrow_in) | (b & borrow_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial a - b - borrow_in, LSB first, one bit per clock, with a valid/ready handshake on both sides.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             ovf
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] diff_r;
  logic             br;
  logic             bit_d;
  logic             bit_bo;
  logic             last;

  full_subtractor u_fs (
    .a          (a_sh[0]),
    .b          (b_sh[0]),
    .borrow_in  (br),
    .diff       (bit_d),
    .borrow_out (bit_bo)
  );

  assign last      = (cnt == CW'(WIDTH - 1));
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign diff      = diff_r;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (in_valid)  state_next = RUN;
      RUN:     if (last)      state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default:                state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      a_sh       <= '0;
      b_sh       <= '0;
      br         <= 1'b0;
      diff_r     <= '0;
      borrow_out <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_sh <= a;
            b_sh <= b;
            br   <= borrow_in;
            cnt  <= '0;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          br     <= bit_bo;
          diff_r <= {bit_d, diff_r[WIDTH-1:1]};
          // Counter parks at 0 rather than stepping to WIDTH, so it never leaves 0..WIDTH-1.
          if (last) begin
            cnt        <= '0;
            borrow_out <= bit_bo;
            ovf        <= br ^ bit_bo;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  a_ready_valid_excl: assert property (@(posedge clk) !(in_ready && out_valid));
  a_cnt_bound:        assert property (@(posedge clk) cnt <= CW'(WIDTH - 1));

endmodule

// File: tb/tb_serial_subtractor.sv
// Randomized and directed checks of serial_subtractor against a cycle-count/arithmetic model.
module tb_serial_subtractor;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         borrow_in;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         borrow_out;
  logic         ovf;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .a          (a),
    .b          (b),
    .borrow_in  (borrow_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .diff       (diff),
    .borrow_out (borrow_out),
    .ovf        (ovf)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: arithmetic result computed at acceptance, plus a latency countdown.
  logic         started = 1'b0;
  logic         m_idle  = 1'b1;
  logic         m_done  = 1'b0;
  int           m_left  = 0;
  logic [W-1:0] m_diff  = '0;
  logic         m_bo    = 1'b0;
  logic         m_ovf   = 1'b0;

  always @(posedge clk) begin
    logic [W:0] full;
    int         s;
    started = 1'b1;
    if (rst) begin
      m_idle = 1'b1;
      m_done = 1'b0;
      m_left = 0;
    end else if (m_idle) begin
      if (in_valid) begin
        full   = {1'b0, a} - {1'b0, b} - (W+1)'(borrow_in);
        s      = int'($signed(a)) - int'($signed(b)) - int'(borrow_in);
        m_diff = full[W-1:0];
        m_bo   = full[W];
        m_ovf  = (s < -(2 ** (W - 1))) || (s > (2 ** (W - 1)) - 1);
        m_left = W;
        m_idle = 1'b0;
      end
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) m_done = 1'b1;
    end else if (m_done && out_ready) begin
      m_done = 1'b0;
      m_idle = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (started && !rst) begin
      chk("in_ready", 32'(in_ready), 32'(m_idle));
      chk("out_valid", 32'(out_valid), 32'(m_done));
      if (m_done) begin
        chk("diff", 32'(diff), 32'(m_diff));
        chk("borrow_out", 32'(borrow_out), 32'(m_bo));
        chk("ovf", 32'(ovf), 32'(m_ovf));
      end
    end
  end

  task automatic scramble(input logic keep_valid_low);
    a         = W'($urandom);
    b         = W'($urandom);
    borrow_in = 1'($urandom);
    in_valid  = keep_valid_low ? 1'b0 : 1'($urandom);
  endtask

  // Called with the DUT idle; returns after the release edge.
  task automatic txn(input logic [W-1:0] ta, input logic [W-1:0] tb2, input logic tbin,
                     input int hold, input logic lit,
                     input logic [W-1:0] ld, input logic lbo, input logic lovf);
    int lat;
    in_valid  = 1'b1;
    a         = ta;
    b         = tb2;
    borrow_in = tbin;
    out_ready = 1'b0;
    @(posedge clk); #1;
    scramble(1'b0);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      scramble(1'b0);
    end
    chk("latency", 32'(lat), 32'(W));
    if (lit) begin
      chk("lit_diff", 32'(diff), 32'(ld));
      chk("lit_borrow", 32'(borrow_out), 32'(lbo));
      chk("lit_ovf", 32'(ovf), 32'(lovf));
      chk("model_diff", 32'(m_diff), 32'(ld));
      chk("model_borrow", 32'(m_bo), 32'(lbo));
      chk("model_ovf", 32'(m_ovf), 32'(lovf));
    end
    repeat (hold) begin
      @(posedge clk); #1;
      scramble(1'b0);
      chk("hold_in_ready", 32'(in_ready), 32'd0);
      chk("hold_diff", 32'(diff), 32'(m_diff));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("released_idle", 32'(in_ready), 32'd1);
    scramble(1'b1);
  endtask

  initial begin
    clk       = 1'b0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    borrow_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_diff", 32'(diff), 32'd0);
    chk("rst_borrow", 32'(borrow_out), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);

    txn(8'h05, 8'h03, 1'b0, 0, 1'b1, 8'h02, 1'b0, 1'b0);
    txn(8'h03, 8'h05, 1'b0, 0, 1'b1, 8'hFE, 1'b1, 1'b0);
    txn(8'h80, 8'h01, 1'b0, 0, 1'b1, 8'h7F, 1'b0, 1'b1);
    txn(8'h00, 8'h00, 1'b1, 0, 1'b1, 8'hFF, 1'b1, 1'b0);
    txn(8'h7F, 8'hFF, 1'b0, 3, 1'b1, 8'h80, 1'b1, 1'b1);

    // Reset in the middle of a run, after four bit cycles.
    in_valid  = 1'b1;
    a         = 8'hAA;
    b         = 8'h33;
    borrow_in = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_diff", 32'(diff), 32'd0);
    chk("midrst_borrow", 32'(borrow_out), 32'd0);
    txn(8'h05, 8'h03, 1'b0, 0, 1'b1, 8'h02, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      txn(W'($urandom), W'($urandom), 1'($urandom), int'($urandom_range(0, 3)),
          1'b0, '0, 1'b0, 1'b0);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
        scramble(1'b1);
      end
    end

    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter WIDTH SHALL default to 8 and give the operand width in bits; legal range 2..32.
REQ-002 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  operand set presented.
REQ-005 in_ready  output  1  block can accept operands.
REQ-006 a  input  WIDTH  minuend.
REQ-007 b  input  WIDTH  subtrahend.
REQ-008 borrow_in  input  1  incoming borrow, sampled with a and b.
REQ-009 out_valid  output  1  result held and valid.
REQ-010 out_ready  input  1  consumer takes the result.
REQ-011 diff  output  WIDTH  a - b - borrow_in, modulo 2^WIDTH.
REQ-012 borrow_out  output  1  final borrow, set when a < b + borrow_in unsigned.
REQ-013 ovf  output  1  signed overflow of the two's-complement subtraction.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-015 in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-016 In IDLE, an edge with in_valid=1 SHALL capture a, b and borrow_in, clear the bit counter to 0, and enter RUN; with in_valid=0 the block SHALL stay in IDLE.
REQ-017 Each RUN cycle SHALL process one bit LSB-first as a full subtraction: d = ai^bi^br, br_next = (~ai&bi)|(~ai&br)|(bi&br).
REQ-018 Each RUN cycle SHALL shift d into the result register from the MSB end and increment the counter.
REQ-019 On the RUN edge where the counter equals WIDTH-1, the block SHALL enter DONE, so out_valid rises exactly WIDTH cycles after the accepting edge.
REQ-020 ovf SHALL equal the borrow into the MSB XOR the borrow out of the MSB, captured on that last RUN edge.
REQ-021 In DONE, diff, borrow_out and ovf SHALL hold stable until an edge with out_ready=1.
REQ-022 An edge in DONE with out_ready=1 SHALL return the block to IDLE; a new operand set is not accepted on that same edge.
REQ-023 Outside DONE, diff, borrow_out and ovf SHALL keep their last values and SHALL NOT be used.
REQ-024 Changes on a, b or borrow_in after acceptance SHALL NOT affect the result in progress.
REQ-025 in_valid during RUN or DONE SHALL be ignored and SHALL NOT be queued.

Reset
REQ-026 rst=1 on an edge SHALL force IDLE, counter=0, and diff, borrow_out, ovf and the internal borrow to 0, in any state including mid-RUN.
REQ-027 The reset values SHALL give in_ready=1 and out_valid=0 on the first cycle after reset.
REQ-028 rst SHALL take priority over in_valid and out_ready on the same edge.

Structure
REQ-029 A shared package SHALL hold the state enum (IDLE/RUN/DONE) and the default width constant.
REQ-030 The per-bit logic SHALL be one sub-module, full_subtractor, with ports a, b, borrow_in, diff and borrow_out; it is the borrow-domain counterpart of full_adder.
REQ-031 The top level SHALL contain only the FSM, the counter, the shift registers and the borrow flip-flop; the target size is 120-400 RTL lines.

Verification
REQ-032 The bench SHALL cover the directed scenarios below, all at WIDTH=8:
- a=0x05, b=0x03, borrow_in=0 -> diff=0x02, borrow_out=0, ovf=0; out_valid rises 8 cycles after acceptance.
- a=0x03, b=0x05, borrow_in=0 -> diff=0xFE, borrow_out=1, ovf=0.
- a=0x80, b=0x01, borrow_in=0 -> diff=0x7F, borrow_out=0, ovf=1.
- a=0x00, b=0x00, borrow_in=1 -> diff=0xFF, borrow_out=1, ovf=0.
- Backpressure: out_ready held low 3 cycles in DONE, with a and b toggling -> outputs stable, in_ready=0; the result is released on the first out_ready=1 edge, then IDLE.
- rst=1 at RUN count 4 -> next cycle IDLE, in_ready=1, out_valid=0; a following 0x05-0x03 transaction gives 0x02.
REQ-033 Formal checks SHALL prove the following properties:
- out_valid and in_ready are never both 1.
- The counter never exceeds WIDTH-1.
- In DONE, {borrow_out,diff} equals the captured {1'b0,a} - b - borrow_in.
